// File: rtl/seq_divider_16.sv
// rtl/seq_divider_16.sv - 16-bit sequential restoring divider, one quotient bit per cycle
//
// Purpose : unsigned (or, with SIGNED_DIV_EN defined, two's complement) 16/16 divide.
//           Magnitudes go through a restoring shift-subtract core, MSB first, over 16 RUN cycles.
//           A zero divisor skips RUN and completes on the next cycle.
// Macro   : SIGNED_DIV_EN - signed operands; quotient truncates toward zero,
//           remainder takes the dividend's sign.
// Ports   : clk          - sole clock, rising edge
//           rst_n        - synchronous active-low reset
//           start        - begin a division; accepted in IDLE or DONE only
//           dividend     - numerator, captured on the accepted start edge
//           divisor      - denominator, captured on the accepted start edge
//           busy         - high in every RUN cycle
//           done         - one-cycle pulse in DONE; results valid
//           quotient     - result quotient, held until the next completion
//           remainder    - result remainder, held until the next completion
//           div_by_zero  - last completed operation had a zero divisor

module seq_divider_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] rem_q;        // partial remainder between iterations (always < divisor)
    logic [15:0] quo_q;        // dividend bits shift out of the top, quotient bits shift in
    logic [15:0] dvs_q;        // captured divisor magnitude
    logic [3:0]  cnt_q;        // iteration counter, 0..15
    logic        busy_q;
    logic        done_q;
    logic [15:0] quotient_q;
    logic [15:0] remainder_q;
    logic        dbz_q;

    logic [16:0] rem_sh;       // 17-bit shifted partial remainder for the trial subtract
    logic [16:0] diff;
    logic [15:0] rem_d;
    logic [15:0] quo_d;
    logic [15:0] mag_a;
    logic [15:0] mag_b;
    logic [15:0] q_fin;
    logic [15:0] r_fin;

`ifdef SIGNED_DIV_EN
    logic neg_q_q;             // operand signs differ: negate quotient
    logic neg_r_q;             // dividend negative: negate remainder
`endif

    // One restoring iteration: shift in the next dividend bit, try subtracting the divisor.
    // A borrow (diff[16]) means the trial failed and the shifted value is kept.
    always_comb begin
        rem_sh = {rem_q, quo_q[15]};
        diff   = rem_sh - {1'b0, dvs_q};
        rem_d  = diff[16] ? rem_sh[15:0] : diff[15:0];
        quo_d  = {quo_q[14:0], ~diff[16]};
    end

`ifdef SIGNED_DIV_EN
    // 16'h8000 maps to itself, which is still the correct unsigned magnitude.
    always_comb begin
        mag_a = dividend[15] ? (16'd0 - dividend) : dividend;
        mag_b = divisor[15]  ? (16'd0 - divisor)  : divisor;
        q_fin = neg_q_q ? (16'd0 - quo_d) : quo_d;
        r_fin = neg_r_q ? (16'd0 - rem_d) : rem_d;
    end
`else
    always_comb begin
        mag_a = dividend;
        mag_b = divisor;
        q_fin = quo_d;
        r_fin = rem_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= 16'd0;
            quo_q       <= 16'd0;
            dvs_q       <= 16'd0;
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= 16'd0;
            remainder_q <= 16'd0;
            dbz_q       <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor == 16'd0) begin
                            // Zero divisor bypasses RUN entirely.
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            quotient_q  <= 16'hFFFF;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            rem_q   <= 16'd0;
                            quo_q   <= mag_a;
                            dvs_q   <= mag_b;
                            cnt_q   <= 4'd0;
`ifdef SIGNED_DIV_EN
                            neg_q_q <= dividend[15] ^ divisor[15];
                            neg_r_q <= dividend[15];
`endif
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here.
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        // Last iteration result and sign fix-up land directly in the output registers.
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= q_fin;
                        remainder_q <= r_fin;
                        dbz_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16.sv
// tb/tb_seq_divider_16.sv - directed self-checking bench for seq_divider_16

module tb_seq_divider_16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider_16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue start with operands, scramble the inputs afterwards, and wait for done.
    // lat counts cycles from the start-sampled cycle to the done cycle (17 for a normal divide).
    // At glitch_at (cycles after the start edge) a spurious start with 50/5 is pulsed.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b, input int glitch_at,
                           output int lat, output int bcnt);
        int cnt;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 16'hA5A5;
        divisor  = 16'h0003;
        cnt  = 0;
        bcnt = 0;
        while (!done && cnt < 40) begin
            if (busy) bcnt++;
            if (cnt == glitch_at) begin
                start    = 1'b1;
                dividend = 16'd50;
                divisor  = 16'd5;
            end
            tick();
            start = 1'b0;
            cnt++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        lat = cnt + 1;
    endtask

    task automatic expect_result(input string tag, input logic [15:0] q, input logic [15:0] r,
                                 input logic dbz, input int lat, input int exp_lat,
                                 input int bcnt, input int exp_bcnt);
        check({tag, "_lat"},  lat,  exp_lat);
        check({tag, "_busy"}, bcnt, exp_bcnt);
        check({tag, "_q"},    {16'd0, quotient},  {16'd0, q});
        check({tag, "_r"},    {16'd0, remainder}, {16'd0, r});
        check({tag, "_dbz"},  {31'd0, div_by_zero}, {31'd0, dbz});
    endtask

    initial begin
        int lat;
        int bcnt;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        tick();
        tick();

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q",    {16'd0, quotient}, 32'd0);
        check("rst_r",    {16'd0, remainder}, 32'd0);
        check("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 100 / 7
        run_div(16'd100, 16'd7, -1, lat, bcnt);
        expect_result("d100_7", 16'd14, 16'd2, 1'b0, lat, 17, bcnt, 16);
        tick();
        check("d100_7_pulse", {31'd0, done}, 32'd0);
        check("d100_7_hold",  {16'd0, quotient}, 32'd14);

`ifdef SIGNED_DIV_EN
        // -7 / 2
        run_div(16'hFFF9, 16'd2, -1, lat, bcnt);
        expect_result("sn7_2", 16'hFFFD, 16'hFFFF, 1'b0, lat, 17, bcnt, 16);
        tick();
        // 7 / -2
        run_div(16'd7, 16'hFFFE, -1, lat, bcnt);
        expect_result("s7_n2", 16'hFFFD, 16'd1, 1'b0, lat, 17, bcnt, 16);
        tick();
        // most negative / -1
        run_div(16'h8000, 16'hFFFF, -1, lat, bcnt);
        expect_result("s8000", 16'h8000, 16'd0, 1'b0, lat, 17, bcnt, 16);
        tick();
`else
        // FFFF / 1
        run_div(16'hFFFF, 16'd1, -1, lat, bcnt);
        expect_result("dffff_1", 16'hFFFF, 16'd0, 1'b0, lat, 17, bcnt, 16);
        tick();
        // 5 / 9
        run_div(16'd5, 16'd9, -1, lat, bcnt);
        expect_result("d5_9", 16'd0, 16'd5, 1'b0, lat, 17, bcnt, 16);
        tick();
        // FFFF / 16 = 4095 r 15
        run_div(16'hFFFF, 16'h0010, -1, lat, bcnt);
        expect_result("dffff_10", 16'h0FFF, 16'h000F, 1'b0, lat, 17, bcnt, 16);
        tick();
`endif

        // 1234 / 0
        run_div(16'd1234, 16'd0, -1, lat, bcnt);
        expect_result("dz", 16'hFFFF, 16'd1234, 1'b1, lat, 1, bcnt, 0);
        tick();
        check("dz_pulse", {31'd0, done}, 32'd0);
        check("dz_busy",  {31'd0, busy}, 32'd0);

        // Nonzero divide clears div_by_zero; spurious start at cycle 5 is ignored
        run_div(16'd100, 16'd7, 4, lat, bcnt);
        expect_result("glitch", 16'd14, 16'd2, 1'b0, lat, 17, bcnt, 16);

        // Back-to-back: start sampled in the DONE cycle
        run_div(16'd1000, 16'd33, -1, lat, bcnt);
        expect_result("b2b", 16'd30, 16'd10, 1'b0, lat, 17, bcnt, 16);
        tick();
        check("b2b_idle", {31'd0, busy}, 32'd0);

        // Reset during run: assert rst_n low at cycle 8
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_q",    {16'd0, quotient}, 32'd0);
        check("abort_r",    {16'd0, remainder}, 32'd0);
        check("abort_dbz",  {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (done || busy) seen++;
            end
            check("abort_no_done", seen, 0);
        end

        // Reset wins over a simultaneous start
        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd2;
        tick();
        start = 1'b0;
        check("rst_prio_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_prio_idle", {31'd0, busy}, 32'd0);

        // Fresh division after reset
        run_div(16'd60000, 16'd7, -1, lat, bcnt);
        expect_result("post_rst", 16'd8571, 16'd3, 1'b0, lat, 17, bcnt, 16);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
